// File: rtl/filt_chain_sched.sv
// Sample/symbol strobe scheduler and stimulus source for the TX_filt -> RCV_filt cascade.
// Define FILT_SCHED_ASK_EN to compile in the LFSR-driven 4-ASK source (mode 2); otherwise mode 2 emits zeros.
module filt_chain_sched #(
    parameter int SAMP_DIV  = 1,
    parameter int SPS       = 4,
    parameter int FLUSH_LEN = 21,
    parameter int RUN_LEN   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic signed [17:0] x_ext,
    output logic signed [17:0] x_out,
    output logic               x_vld,
    output logic               sym_en,
    output logic               busy,
    output logic               done
);

    localparam int DATA_W = 18;
    localparam logic [7:0]  DIV_LAST   = 8'(SAMP_DIV - 1);
    localparam logic [7:0]  SYM_LAST   = 8'(SPS - 1);
    localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_LEN - 1);
    localparam logic [15:0] RUN_LAST   = 16'(RUN_LEN - 1);
    localparam logic signed [DATA_W-1:0] IMPULSE = 18'sd131071;

    typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_RUN, ST_DRAIN} state_t;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [7:0]  r_div;
    logic [15:0] r_cnt;
    logic [7:0]  r_sym;
    logic        r_first;
    logic        r_drain_end;
    logic        w_tick;
    logic signed [DATA_W-1:0] w_run_x;

`ifdef FILT_SCHED_ASK_EN
    localparam logic [14:0] LFSR_SEED = 15'h0001;
    logic [14:0] r_lfsr;

    function automatic logic signed [DATA_W-1:0] ask_level(input logic [1:0] s);
        case (s)
            2'b00:   return -18'sd98304;
            2'b01:   return -18'sd32768;
            2'b10:   return 18'sd32768;
            default: return 18'sd98304;
        endcase
    endfunction
`endif

    assign w_tick = (r_div == DIV_LAST);

    always_comb begin
        w_run_x = '0;
        case (r_mode)
            2'd0: w_run_x = x_ext;
            2'd1: w_run_x = r_first ? IMPULSE : '0;
`ifdef FILT_SCHED_ASK_EN
            // zero-stuffed upsampling: only the first sample of each symbol carries a level
            2'd2: w_run_x = (r_sym == 8'd0) ? ask_level(r_lfsr[1:0]) : '0;
`endif
            default: w_run_x = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= 2'd0;
            r_div       <= 8'd0;
            r_cnt       <= 16'd0;
            r_sym       <= 8'd0;
            r_first     <= 1'b0;
            r_drain_end <= 1'b0;
            x_out       <= '0;
            x_vld       <= 1'b0;
            sym_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef FILT_SCHED_ASK_EN
            r_lfsr      <= LFSR_SEED;
`endif
        end else begin
            x_vld  <= 1'b0;
            sym_en <= 1'b0;
            done   <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_div <= w_tick ? 8'd0 : r_div + 8'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        r_state <= ST_FLUSH;
                        r_mode  <= mode;
                        r_div   <= 8'd0;
                        r_cnt   <= 16'd0;
                        r_sym   <= 8'd0;
                        r_first <= 1'b1;
                        busy    <= 1'b1;
`ifdef FILT_SCHED_ASK_EN
                        r_lfsr  <= LFSR_SEED;
`endif
                    end
                end
                ST_FLUSH: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= 16'd0;
                    end else if (w_tick) begin
                        x_out <= '0;
                        x_vld <= 1'b1;
                        if (r_cnt == FLUSH_LAST) begin
                            r_state <= ST_RUN;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= 16'd0;
                    end else if (w_tick) begin
                        x_out   <= w_run_x;
                        x_vld   <= 1'b1;
                        sym_en  <= (r_sym == 8'd0);
                        r_first <= 1'b0;
                        r_sym   <= (r_sym == SYM_LAST) ? 8'd0 : r_sym + 8'd1;
`ifdef FILT_SCHED_ASK_EN
                        if (r_sym == 8'd0) begin
                            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
                        end
`endif
                        // RUN_LEN of zero leaves the run open-ended until stop
                        if ((RUN_LEN != 0) && (r_cnt == RUN_LAST)) begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // one extra cycle after the last drain sample before done/idle
                    if (r_drain_end) begin
                        r_state     <= ST_IDLE;
                        r_drain_end <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (w_tick) begin
                        x_out <= '0;
                        x_vld <= 1'b1;
                        if (r_cnt == FLUSH_LAST) begin
                            r_drain_end <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
